debug_mem_arb: RTL and testbench

Two-master arbiter sharing one 32-bit valid/ready memory port between the hart load/store path (M0) and the debug system-bus/abstract-memory path (M1).
Sits in the SYS_CLK domain between the debug bridge's memory-side outputs, the CPU data port and the system memory/peripheral fabric.
Requests are registered toward the slave and responses are registered back to the winning master.
Optionally returns an error response when the slave never answers.

---
 rtl/debug_mem_arb.sv | 178 +++++++++++++++++
 tb/tb_debug_mem_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_arb.sv
// debug_mem_arb: arbitrates the CPU (M0) and debug (M1) masters onto one registered valid/ready slave port.
// Define DEBUG_MEM_ARB_TIMEOUT_EN to answer with an error response when the slave never completes.
module debug_mem_arb #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        HALTED,
  input  logic        M0_VALID,
  input  logic [3:0]  M0_WSTB,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_READY,
  output logic [31:0] M0_RDATA,
  output logic        M0_EXCEPT,
  input  logic        M1_VALID,
  input  logic [3:0]  M1_WSTB,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_READY,
  output logic [31:0] M1_RDATA,
  output logic        M1_EXCEPT,
  output logic        S_VALID,
  input  logic        S_READY,
  output logic [3:0]  S_WSTB,
  output logic [31:0] S_ADDR,
  output logic [31:0] S_WDATA,
  input  logic [31:0] S_RDATA,
  input  logic        S_EXCEPT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** TO_W) - 1) begin : g_param_check
    $error("debug_mem_arb: TIMEOUT_CYCLES does not fit in TO_W bits");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_gnt;
  logic        r_last;
  logic        w_win;
  logic        w_accept;
  logic        w_finish;
  logic        w_timeout;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_except;

  logic        r_s_valid;
  logic [3:0]  r_s_wstb;
  logic [31:0] r_s_addr;
  logic [31:0] r_s_wdata;
  logic        r_m0_ready;
  logic [31:0] r_m0_rdata;
  logic        r_m0_except;
  logic        r_m1_ready;
  logic [31:0] r_m1_rdata;
  logic        r_m1_except;

`ifdef DEBUG_MEM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt;

  // Counter holds the number of BUSY cycles already spent without S_READY.
  assign w_timeout = (r_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !S_READY;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == BUSY && !S_READY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A timeout completion returns zero data with the error flag set.
  assign w_rsp_rdata  = S_READY ? S_RDATA : 32'h0;
  assign w_rsp_except = S_READY ? S_EXCEPT : 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    if (HALTED) begin
      w_win = M1_VALID;
    end else if (M0_VALID && M1_VALID) begin
      w_win = ~r_last;
    end else begin
      w_win = M1_VALID;
    end
    case (r_state)
      IDLE: begin
        if (M0_VALID || M1_VALID) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (S_READY || w_timeout) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gnt       <= 1'b0;
      r_last      <= 1'b1;
      r_s_valid   <= 1'b0;
      r_s_wstb    <= 4'h0;
      r_s_addr    <= 32'h0;
      r_s_wdata   <= 32'h0;
      r_m0_ready  <= 1'b0;
      r_m0_rdata  <= 32'h0;
      r_m0_except <= 1'b0;
      r_m1_ready  <= 1'b0;
      r_m1_rdata  <= 32'h0;
      r_m1_except <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s_valid <= 1'b1;
        r_gnt     <= w_win;
        r_s_wstb  <= w_win ? M1_WSTB  : M0_WSTB;
        r_s_addr  <= w_win ? M1_ADDR  : M0_ADDR;
        r_s_wdata <= w_win ? M1_WDATA : M0_WDATA;
      end
      if (w_finish) begin
        r_s_valid <= 1'b0;
        r_last    <= r_gnt;
        if (r_gnt) begin
          r_m1_ready  <= 1'b1;
          r_m1_rdata  <= w_rsp_rdata;
          r_m1_except <= w_rsp_except;
        end else begin
          r_m0_ready  <= 1'b1;
          r_m0_rdata  <= w_rsp_rdata;
          r_m0_except <= w_rsp_except;
        end
      end
      if (r_state == DONE) begin
        r_m0_ready <= 1'b0;
        r_m1_ready <= 1'b0;
      end
    end
  end

  assign S_VALID   = r_s_valid;
  assign S_WSTB    = r_s_wstb;
  assign S_ADDR    = r_s_addr;
  assign S_WDATA   = r_s_wdata;
  assign M0_READY  = r_m0_ready;
  assign M0_RDATA  = r_m0_rdata;
  assign M0_EXCEPT = r_m0_except;
  assign M1_READY  = r_m1_ready;
  assign M1_RDATA  = r_m1_rdata;
  assign M1_EXCEPT = r_m1_except;

endmodule

// File: tb/tb_debug_mem_arb.sv
// Self-checking bench for debug_mem_arb: transaction-level reference model plus directed scenarios.
module tb_debug_mem_arb;
  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        HALTED = 1'b0;
  logic [1:0]  mv = 2'b00;
  logic [3:0]  mwstb[2];
  logic [31:0] maddr[2];
  logic [31:0] mwdata[2];
  logic [1:0]  mrdy;
  logic [1:0]  mexc;
  logic [31:0] mrdata[2];
  logic        S_VALID;
  logic        S_READY = 1'b0;
  logic        S_EXCEPT = 1'b0;
  logic [3:0]  S_WSTB;
  logic [31:0] S_ADDR;
  logic [31:0] S_WDATA;
  logic [31:0] S_RDATA = 32'h0;

  always #5 CLK = ~CLK;

  debug_mem_arb #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .HALTED(HALTED),
    .M0_VALID(mv[0]), .M0_WSTB(mwstb[0]), .M0_ADDR(maddr[0]), .M0_WDATA(mwdata[0]),
    .M0_READY(mrdy[0]), .M0_RDATA(mrdata[0]), .M0_EXCEPT(mexc[0]),
    .M1_VALID(mv[1]), .M1_WSTB(mwstb[1]), .M1_ADDR(maddr[1]), .M1_WDATA(mwdata[1]),
    .M1_READY(mrdy[1]), .M1_RDATA(mrdata[1]), .M1_EXCEPT(mexc[1]),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_WSTB(S_WSTB), .S_ADDR(S_ADDR),
    .S_WDATA(S_WDATA), .S_RDATA(S_RDATA), .S_EXCEPT(S_EXCEPT)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, response pulse, then free again.
  bit          inflight, resp;
  int          who, last, waited;
  logic        e_sv;
  logic [3:0]  e_wstb;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_rdy, e_exc;
  logic [31:0] e_rdata[2];

  task automatic mdl_reset();
    inflight = 0; resp = 0; who = 0; last = 1; waited = 0;
    e_sv = 1'b0; e_wstb = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    e_rdy = 2'b00; e_exc = 2'b00; e_rdata[0] = 32'h0; e_rdata[1] = 32'h0;
  endtask

  task automatic mdl_finish(input logic [31:0] d, input logic x);
    e_sv = 1'b0;
    e_rdy[who] = 1'b1;
    e_rdata[who] = d;
    e_exc[who] = x;
    last = who;
    inflight = 0;
    resp = 1;
  endtask

  task automatic mdl_step();
    if (resp) begin
      e_rdy = 2'b00;
      resp = 0;
    end else if (inflight) begin
      waited++;
      if (S_READY) mdl_finish(S_RDATA, S_EXCEPT);
`ifdef DEBUG_MEM_ARB_TIMEOUT_EN
      else if (waited == TO) mdl_finish(32'h0, 1'b1);
`endif
    end else if (mv != 2'b00) begin
      if (HALTED) who = mv[1] ? 1 : 0;
      else if (mv == 2'b11) who = 1 - last;
      else who = mv[1] ? 1 : 0;
      inflight = 1;
      waited = 0;
      e_sv = 1'b1;
      e_wstb = mwstb[who];
      e_addr = maddr[who];
      e_wdata = mwdata[who];
    end
  endtask

  task automatic compare();
    chk("S_VALID", 32'(S_VALID), 32'(e_sv));
    if (e_sv) begin
      chk("S_WSTB", 32'(S_WSTB), 32'(e_wstb));
      chk("S_ADDR", S_ADDR, e_addr);
      chk("S_WDATA", S_WDATA, e_wdata);
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("M%0d_READY", i), 32'(mrdy[i]), 32'(e_rdy[i]));
      chk($sformatf("M%0d_RDATA", i), mrdata[i], e_rdata[i]);
      chk($sformatf("M%0d_EXCEPT", i), 32'(mexc[i]), 32'(e_exc[i]));
    end
  endtask

  // Master mode: 0 = no new requests, 1 = random requests, 2 = always valid.
  int mode[2];
  bit slave_auto = 0;
  bit halt_rand = 0;

  task automatic new_payload(input int i);
    mwstb[i]  = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
    maddr[i]  = $urandom;
    mwdata[i] = $urandom;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (mrdy[i]) begin
        if (mode[i] == 2) new_payload(i);
        else mv[i] = 1'b0;
      end else if (!mv[i] && mode[i] == 1 && $urandom_range(3) == 0) begin
        mv[i] = 1'b1;
        new_payload(i);
      end
    end
    if (slave_auto) begin
      S_READY  = ($urandom_range(2) == 0);
      S_RDATA  = $urandom;
      S_EXCEPT = ($urandom_range(7) == 0);
    end
    if (halt_rand && $urandom_range(15) == 0) HALTED = ~HALTED;
  endtask

  task automatic tick();
    @(posedge CLK);
    mdl_step();
    @(negedge CLK);
    compare();
    drive_inputs();
  endtask

  task automatic quiesce();
    int n;
    mode[0] = 0; mode[1] = 0;
    slave_auto = 1; halt_rand = 0;
    n = 0;
    while (n < 300 && !(mv == 2'b00 && !inflight && !resp)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL quiesce: arbiter still busy after %0d cycles, required idle", n);
    end
    slave_auto = 0;
    S_READY = 1'b0;
    S_EXCEPT = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rst_S_VALID", 32'(S_VALID), 32'h0);
    chk("rst_S_ADDR", S_ADDR, 32'h0);
    chk("rst_S_WSTB", 32'(S_WSTB), 32'h0);
    chk("rst_S_WDATA", S_WDATA, 32'h0);
    chk("rst_READY", 32'(mrdy), 32'h0);
    chk("rst_EXCEPT", 32'(mexc), 32'h0);
    chk("rst_M0_RDATA", mrdata[0], 32'h0);
    chk("rst_M1_RDATA", mrdata[1], 32'h0);
    mv = 2'b00; HALTED = 1'b0; S_READY = 1'b0; S_EXCEPT = 1'b0;
    mdl_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int q[$];
    int n0, n1, n, c;
    bit any_rdy;
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; mwstb[i] = 4'h0; maddr[i] = 32'h0; mwdata[i] = 32'h0;
    end
    mdl_reset();
    do_reset();

    // Single read from M0, slave answers in the third S_VALID cycle.
    mv[0] = 1'b1; mwstb[0] = 4'h0; maddr[0] = 32'h80000010; mwdata[0] = $urandom;
    tick();
    chk("t1_S_VALID", 32'(S_VALID), 32'h1);
    chk("t1_S_ADDR", S_ADDR, 32'h80000010);
    tick();
    tick();
    S_READY = 1'b1; S_RDATA = 32'hDEADBEEF; S_EXCEPT = 1'b0;
    tick();
    chk("t1_M0_READY", 32'(mrdy[0]), 32'h1);
    chk("t1_M0_RDATA", mrdata[0], 32'hDEADBEEF);
    chk("t1_M0_EXCEPT", 32'(mexc[0]), 32'h0);
    chk("t1_M1_READY", 32'(mrdy[1]), 32'h0);
    S_READY = 1'b0;
    tick();
    chk("t1_M0_READY_pulse", 32'(mrdy[0]), 32'h0);

    // Contention with HALTED=0 right after reset: M0, M1, M0, M1.
    do_reset();
    mode[0] = 2; mode[1] = 2; slave_auto = 1;
    mv = 2'b11; new_payload(0); new_payload(1);
    n = 0;
    while (n < 200 && q.size() < 4) begin
      tick();
      if (mrdy[0]) q.push_back(0);
      if (mrdy[1]) q.push_back(1);
      n++;
    end
    chk("t2_grants", 32'(q.size()), 32'd4);
    n0 = 0; n1 = 0;
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("t2_order%0d", i), 32'(q[i]), 32'(i % 2));
      if (q[i] == 0) n0++; else n1++;
    end
    chk("t2_m0_pulses", 32'(n0), 32'd2);
    chk("t2_m1_pulses", 32'(n1), 32'd2);
    quiesce();

    // HALTED=1 with both valid: M1 starves M0 until M1 drops.
    HALTED = 1'b1;
    mode[0] = 2; mode[1] = 2; slave_auto = 1;
    mv = 2'b11; new_payload(0); new_payload(1);
    n0 = 0; n1 = 0; n = 0;
    while (n < 300 && n1 < 3) begin
      tick();
      if (mrdy[0]) n0++;
      if (mrdy[1]) n1++;
      n++;
    end
    chk("t3_m1_grants", 32'(n1), 32'd3);
    chk("t3_m0_starved", 32'(n0), 32'd0);
    mode[1] = 0;
    n = 0;
    while (n < 100 && n0 == 0) begin
      tick();
      if (mrdy[0]) n0++;
      n++;
    end
    chk("t3_m0_after_m1_drop", 32'(n0), 32'd1);
    quiesce();
    HALTED = 1'b0;

    // M1 write with a slave error.
    mv[1] = 1'b1; mwstb[1] = 4'h3; maddr[1] = $urandom; mwdata[1] = 32'h12345678;
    tick();
    chk("t4_S_WSTB", 32'(S_WSTB), 32'h3);
    chk("t4_S_WDATA", S_WDATA, 32'h12345678);
    S_READY = 1'b1; S_EXCEPT = 1'b1; S_RDATA = $urandom;
    tick();
    chk("t4_M1_READY", 32'(mrdy[1]), 32'h1);
    chk("t4_M1_EXCEPT", 32'(mexc[1]), 32'h1);
    chk("t4_M0_READY", 32'(mrdy[0]), 32'h0);
    S_READY = 1'b0; S_EXCEPT = 1'b0;
    tick();
    quiesce();

    // Silent slave.
    mv[0] = 1'b1; mwstb[0] = 4'h0; maddr[0] = $urandom; mwdata[0] = $urandom;
    n = 0; any_rdy = 0;
    for (c = 0; c < 100; c++) begin
      tick();
      if (mrdy != 2'b00) any_rdy = 1;
      if (!S_VALID) break;
      n++;
    end
`ifdef DEBUG_MEM_ARB_TIMEOUT_EN
    chk("t5_busy_cycles", 32'(n), 32'd4);
    chk("t5_M0_READY", 32'(mrdy[0]), 32'h1);
    chk("t5_M0_EXCEPT", 32'(mexc[0]), 32'h1);
    chk("t5_M0_RDATA", mrdata[0], 32'h0);
`else
    chk("t5_busy_cycles", 32'(n), 32'd100);
    chk("t5_no_ready", 32'(any_rdy), 32'h0);
`endif
    quiesce();

    // Reset while BUSY, then contention grants M0 first.
    mv[0] = 1'b1; new_payload(0);
    tick();
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    chk("t6_S_VALID", 32'(S_VALID), 32'h0);
    chk("t6_M0_READY", 32'(mrdy[0]), 32'h0);
    chk("t6_M1_READY", 32'(mrdy[1]), 32'h0);
    mv = 2'b00;
    mdl_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    mv = 2'b11; new_payload(0); new_payload(1);
    slave_auto = 1;
    tick();
    chk("t6_first_grant_addr", S_ADDR, maddr[0]);
    quiesce();

    // Random traffic, random HALTED, random slave latency.
    mode[0] = 1; mode[1] = 1; slave_auto = 1; halt_rand = 1;
    repeat (3000) tick();
    quiesce();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
